count_sequence_monitor: RTL
===========================

// Module: count_sequence_monitor
// PURPOSE
//  Downstream checker for the 4-bit counter: samples its count output every valid cycle and
//  verifies the sequence is prev+1 mod 2^CNT_W. Reports wrap events, mismatch pulses, a sticky
//  error flag and saturating event counts. Sits between the counter and the board status LEDs / debug taps.
// PARAMETERS
//  CNT_W      4  width of monitored count
//  WRAP_W     8  width of wrap_count (saturating)
//  ERR_W      8  width of err_count (saturating)
//  ERR_LIMIT  3  consecutive mismatches that drop lock (range 1..15)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst         in   1       asynchronous, active-low reset
//  cnt_in      in   CNT_W   count value from upstream counter
//  cnt_valid   in   1       cnt_in is a new sample this cycle
//  clear       in   1       synchronous clear of counts, sticky flag, lock
//  locked      out  1       monitor has a reference value and is tracking
//  wrap_pulse  out  1       1-cycle pulse: valid max->0 transition seen
//  wrap_count  out  WRAP_W  number of wraps, saturates at all-ones
//  err_pulse   out  1       1-cycle pulse: sample mismatched expectation
//  err_sticky  out  1       set on any mismatch, cleared only by rst/clear
//  err_count   out  ERR_W   number of mismatches, saturates at all-ones
// BEHAVIOUR
//  - Reset (rst=0, async): state=SYNC, prev=0, consec=0, all outputs 0.
//  - All outputs registered; pulses/counts update 1 cycle after the sampled cnt_valid edge.
//  - FSM SYNC: on cnt_valid -> prev<=cnt_in, consec<=0, go TRACK; no pulses. locked=0.
//  - FSM TRACK (locked=1): on cnt_valid, exp=prev+1 (mod 2^CNT_W, carry dropped):
//      cnt_in==exp  -> ok; consec<=0; if prev==all-ones (cnt_in==0) wrap_pulse=1, wrap_count++.
//      otherwise    -> err_pulse=1, err_sticky=1, err_count++, consec++; prev<=cnt_in (resync).
//      consec reaching ERR_LIMIT -> go SYNC (locked=0 next cycle), consec<=0.
//    prev<=cnt_in on every valid sample in TRACK.
//  - cnt_valid=0: no state change, pulses 0.
//  - Saturation: wrap_count/err_count hold at all-ones; further events still pulse.
//  - clear=1: counts, err_sticky, consec -> 0, state -> SYNC next edge; clear beats a
//    simultaneous cnt_valid (sample discarded, no pulses).
//  - Mismatch on a would-be wrap (prev=max, cnt_in!=0): error only, no wrap_pulse.
//  - rst asserted mid-operation: immediate return to reset values regardless of state.
// CONFIGURATION
//  MON_HOLD_EN defined: in TRACK, cnt_in==prev is a legal hold (counter paused): no pulse,
//    consec<=0, not counted.
//  MON_HOLD_EN undefined: cnt_in==prev is a mismatch like any other.
// STRUCTURE
//  - Package count_mon_pkg: state typedef {SYNC, TRACK}, default widths, ERR_LIMIT bound.
//  - Sub-module sat_counter #(W): inc/clr inputs, saturating at all-ones; instantiated
//    twice (wrap_count, err_count). FSM, compare and consec counter stay in top level.
// TESTING
//  1 rst low, then 20 valid samples 0,1..15,0,1,2,3 -> locked=1 after 1st; one wrap_pulse
//    after 15->0; wrap_count=1; err_count=0, err_sticky=0.
//  2 Locked at 5, feed 9 -> err_pulse 1 cycle, err_count=1, err_sticky=1; then 10,11 ->
//    no further errors (resynced to 9), sticky stays 1.
//  3 Three consecutive bad samples 3,7,2 after 1 -> err_count=3, locked drops to 0 next cycle;
//    next valid 4 relocks with no pulse.
//  4 Hold: samples 6,6 -> with MON_HOLD_EN no error; without it err_pulse once, err_count=1.
//  5 clear=1 coincident with cnt_valid (sample 8) -> counts/sticky 0, locked=0, no pulse;
//    WRAP_W=2, 5 wraps -> wrap_count stays 3, wrap_pulse still fires 5 times.
//  6 rst low mid-TRACK with err_count=2 -> all outputs 0 asynchronously, before next clk edge.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared types and default widths for the count sequence monitor.
// Optional legal-hold feature is selected by the MON_HOLD_EN macro in the top level.
// No logic here; types and constants only.
package count_mon_pkg;

  // Monitor FSM: waiting for a reference sample, or tracking the sequence
  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } mon_state_t;

  localparam int CNT_W_DEF     = 4;
  localparam int WRAP_W_DEF    = 8;
  localparam int ERR_W_DEF     = 8;
  localparam int ERR_LIMIT_DEF = 3;

  // Consecutive-mismatch counter only needs to reach ERR_LIMIT (max 15)
  localparam int ERR_LIMIT_MAX = 15;
  localparam int CONSEC_W      = 4;

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones; synchronous clear has priority over increment.
// Latency: count reflects inc/clr one clock after they are sampled.
// No backpressure: increments past saturation are silently dropped.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc until all-ones, then hold; clear wins over inc
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/count_sequence_monitor.sv
// Checks that valid count samples follow prev+1 mod 2^CNT_W; flags wraps and mismatches.
// Latency: all outputs registered, one clock after the sampled cnt_valid. MON_HOLD_EN: cnt_in==prev is a legal hold.
// No backpressure: every valid sample is consumed; clear discards a coincident sample.
module count_sequence_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int WRAP_W    = WRAP_W_DEF,
  parameter int ERR_W     = ERR_W_DEF,
  parameter int ERR_LIMIT = ERR_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic              clear,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_count
);

  mon_state_t          state;
  logic [CNT_W-1:0]    prev;
  logic [CONSEC_W-1:0] consec;

  logic [CNT_W-1:0]    exp_cnt;
  logic [CONSEC_W-1:0] consec_inc;
  logic                take;
  logic                in_track;
  logic                seq_ok;
  logic                seq_hold;
  logic                wrap_evt;
  logic                err_evt;

  // Classify the current sample against the expected successor of prev
  always_comb begin
    exp_cnt    = prev + CNT_W'(1);
    consec_inc = consec + CONSEC_W'(1);
    take       = cnt_valid && !clear;
    in_track   = (state == TRACK);
    seq_ok     = (cnt_in == exp_cnt);
`ifdef MON_HOLD_EN
    seq_hold   = (cnt_in == prev);
`else
    seq_hold   = 1'b0;
`endif
    // A wrap is only credited on a correct max->0 step; a bad value after max is an error only
    wrap_evt   = take && in_track && seq_ok && (&prev);
    err_evt    = take && in_track && !seq_ok && !seq_hold;
  end

  // Lock FSM, reference value, consecutive-error tracking and registered flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SYNC;
      prev       <= '0;
      consec     <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      wrap_pulse <= wrap_evt;
      err_pulse  <= err_evt;
      if (clear) begin
        state      <= SYNC;
        locked     <= 1'b0;
        consec     <= '0;
        err_sticky <= 1'b0;
      end else if (cnt_valid) begin
        // Always resync to the latest sample so a single glitch costs one error
        prev <= cnt_in;
        case (state)
          SYNC: begin
            state  <= TRACK;
            locked <= 1'b1;
            consec <= '0;
          end
          TRACK: begin
            if (err_evt) begin
              err_sticky <= 1'b1;
              if (consec_inc == CONSEC_W'(ERR_LIMIT)) begin
                state  <= SYNC;
                locked <= 1'b0;
                consec <= '0;
              end else begin
                consec <= consec_inc;
              end
            end else begin
              consec <= '0;
            end
          end
        endcase
      end
    end
  end

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (wrap_evt),
    .count (wrap_count)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (err_evt),
    .count (err_count)
  );

endmodule
